wb_ram_arbiter: RTL

//  Two-master Wishbone B3 arbiter in front of the single program/data RAM slave.

---
 rtl/wb_arb_pkg.sv | 12 +
 rtl/wb_ram_arbiter_if.sv | 17 +
 rtl/wb_arb_watchdog.sv | 19 +
 rtl/wb_ram_arbiter.sv | 89 ++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// wb_arb_pkg: shared state encoding and arbitration-mode constants for the RAM arbiter.
package wb_arb_pkg;
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        GNT0 = 3'd1,
        GNT1 = 3'd2,
        ABT0 = 3'd3,
        ABT1 = 3'd4
    } state_e;
    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
endpackage

// File: rtl/wb_ram_arbiter_if.sv
// wb_ram_arbiter_if: one Wishbone B3 port; master drives the request, slave drives the response.
interface wb_ram_arbiter_if #(parameter int ADR_W = 32, parameter int DAT_W = 32);
    localparam int SEL_W = DAT_W / 8;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat_w;
    logic [DAT_W-1:0] dat_r;
    logic [SEL_W-1:0] sel;
    logic             we;
    logic             cyc;
    logic             stb;
    logic [2:0]       cti;
    logic [1:0]       bte;
    logic             ack;
    logic             err;
    modport master (output adr, dat_w, sel, we, cyc, stb, cti, bte, input dat_r, ack, err);
    modport slave  (input adr, dat_w, sel, we, cyc, stb, cti, bte, output dat_r, ack, err);
endinterface

// File: rtl/wb_arb_watchdog.sv
// wb_arb_watchdog: saturating stall counter; expired_o flags the stalled cycle that reaches TIMEOUT.
module wb_arb_watchdog #(parameter int TIMEOUT = 255) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);
    localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [W-1:0] MAX  = W'(TIMEOUT);
    localparam logic [W-1:0] LAST = W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != MAX) ? cnt_q + 1'b1 : cnt_q;
    // Expire on the stalled cycle whose increment would make the count equal TIMEOUT.
    assign expired_o = (TIMEOUT > 0) && inc_i && cnt_q == LAST;
    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
endmodule

// File: rtl/wb_ram_arbiter.sv
// wb_ram_arbiter: two-master Wishbone arbiter for the program/data RAM with stall watchdog.
module wb_ram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int ADR_W   = 32,
    parameter int DAT_W   = 32,
    parameter int RR_MODE = ARB_FIXED,
    parameter int TIMEOUT = 255
) (
    input  logic             clk_i,
    input  logic             rst_i,
    wb_ram_arbiter_if.slave  m0,
    wb_ram_arbiter_if.slave  m1,
    wb_ram_arbiter_if.master s,
    output logic [1:0]       gnt_o
);
    localparam int SEL_W = DAT_W / 8;
    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             g0, g1, want1, stall, expired;
    logic [ADR_W-1:0] adr;
    logic [DAT_W-1:0] dat;
    logic [SEL_W-1:0] sel;
    logic [2:0]       cti;
    logic [1:0]       bte;
    logic             we, cyc, stb;

    assign g0 = state_q == GNT0;
    assign g1 = state_q == GNT1;

    always_comb begin
        adr = g0 ? m0.adr   : g1 ? m1.adr   : '0;
        dat = g0 ? m0.dat_w : g1 ? m1.dat_w : '0;
        sel = g0 ? m0.sel   : g1 ? m1.sel   : '0;
        cti = g0 ? m0.cti   : g1 ? m1.cti   : '0;
        bte = g0 ? m0.bte   : g1 ? m1.bte   : '0;
        we  = g0 ? m0.we    : g1 ? m1.we    : 1'b0;
        cyc = g0 ? m0.cyc   : g1 ? m1.cyc   : 1'b0;
        stb = g0 ? m0.stb   : g1 ? m1.stb   : 1'b0;
        stall = (g0 || g1) && stb && !s.ack && !s.err;
    end

    assign s.adr   = adr;
    assign s.dat_w = dat;
    assign s.sel   = sel;
    assign s.cti   = cti;
    assign s.bte   = bte;
    assign s.we    = we;
    assign s.cyc   = cyc;
    assign s.stb   = stb;
    assign m0.dat_r = s.dat_r;
    assign m1.dat_r = s.dat_r;
    assign m0.ack   = g0 && s.ack;
    assign m1.ack   = g1 && s.ack;
    assign m0.err   = (g0 && s.err) || state_q == ABT0;
    assign m1.err   = (g1 && s.err) || state_q == ABT1;
    assign gnt_o    = {g1 || state_q == ABT1, g0 || state_q == ABT0};

    always_comb begin
        // On a tie m1 wins only in round-robin mode when m0 was granted last.
        want1   = m1.cyc && (!m0.cyc || (RR_MODE == ARB_RR && !last_q));
        state_d = state_q;
        case (state_q)
            IDLE:    if (m0.cyc || m1.cyc) state_d = want1 ? GNT1 : GNT0;
            GNT0:    state_d = expired ? ABT0 : m0.cyc ? GNT0 : m1.cyc ? GNT1 : IDLE;
            GNT1:    state_d = expired ? ABT1 : m1.cyc ? GNT1 : m0.cyc ? GNT0 : IDLE;
            default: state_d = IDLE;
        endcase
        last_d = (state_d != state_q && state_d == GNT1) ? 1'b1 :
                 (state_d != state_q && state_d == GNT0) ? 1'b0 : last_q;
    end

    wb_arb_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (!stall || state_d != state_q),
        .inc_i     (stall),
        .expired_o (expired)
    );

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
endmodule
